// File: rtl/nn_fmt_pkg.sv
// rtl/nn_fmt_pkg.sv - shared sign-magnitude score format for the digit classifier
// Purpose: widths, codes and helpers shared by the output layer and max_in_10.
//   DW       score / activation / weight width
//   N_OUT    neuron count expected by max_in_10
//   SAT_CODE positive-saturation score, ranked highest by max_in_10
//   lane_of  packed lane index of neuron d (max_in_10 reports oIndex = 9 - lane)
package nn_fmt;

  localparam int DW = 8;
  localparam int N_OUT = 10;
  localparam logic [DW-1:0] SAT_CODE = 8'h80;
  localparam logic [DW-1:0] NEG_SAT_CODE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_QUANT
  } mac_state_t;

  function automatic int lane_of(input int d);
    return N_OUT - 1 - d;
  endfunction

  function automatic logic sm_sign(input logic [DW-1:0] x);
    return x[DW-1];
  endfunction

  function automatic logic [DW-2:0] sm_mag(input logic [DW-1:0] x);
    return x[DW-2:0];
  endfunction

endpackage

// File: rtl/sm_mac_lane.sv
// rtl/sm_mac_lane.sv - one output neuron: sign-magnitude MAC plus quantize/clamp
// Purpose: accumulates act*w products in two's complement and presents the
//   8-bit sign-magnitude score of the current accumulator.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     zero the accumulator (start of an inference)
//   mac_en    add act*w into the accumulator on this edge
//   act, w    sign-magnitude operands
//   score     quantized score of the accumulator (combinational)
module sm_mac_lane
  import nn_fmt::*;
#(
  parameter int ACC_W = 20,
  parameter int SHIFT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          mac_en,
  input  logic [DW-1:0] act,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] score
);

  localparam int PW = 2 * (DW - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = 127;
  localparam logic signed [ACC_W-1:0] Q_MIN = -127;

  logic [PW-1:0]            prod_mag;
  logic                     prod_neg;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  q;
  logic signed [ACC_W-1:0]  q_neg;

  // 0x80 has magnitude 0, so -0 inputs contribute nothing without a special case.
  assign prod_mag = PW'(sm_mag(act)) * PW'(sm_mag(w));
  assign prod_neg = sm_sign(act) ^ sm_sign(w);
  assign prod_ext = {{(ACC_W-PW){1'b0}}, prod_mag};
  assign term     = prod_neg ? -prod_ext : prod_ext;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= acc + term;
    end
  end

  // Arithmetic shift floors toward -inf, so small negative sums land on -1.
  assign q     = acc >>> SHIFT;
  assign q_neg = -q;

  always_comb begin
    score = '0;
    if (q > Q_MAX) begin
      score = SAT_CODE;
    end else if (q < Q_MIN) begin
      score = NEG_SAT_CODE;
    end else if (!q[ACC_W-1]) begin
      score = {1'b0, q[DW-2:0]};
    end else begin
      score = {1'b1, q_neg[DW-2:0]};
    end
  end

endmodule

// File: rtl/output_layer_mac.sv
// rtl/output_layer_mac.sv - classifier output layer: MAC over hidden activations, quantized scores
// Purpose: one inference per start pulse; N_IN activations are accepted, each
//   multiplied against a weight-ROM row of N_OUT lanes, then the sums are
//   quantized and packed for max_in_10.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       begin inference (IDLE only)
//   act_in      activation, sign-magnitude; act_valid/act_ready handshake
//   w_addr      ROM row address = number of accepted activations
//   w_data      ROM row (1-cycle registered read), neuron d at lane_of(d)
//   data_out    packed scores, neuron d at lane_of(d); data_valid pulses on update
//   busy        high in ACCUM, DRAIN and QUANT
module output_layer_mac
  import nn_fmt::*;
#(
  parameter int N_IN  = 32,
  parameter int N_OUT = 10,
  parameter int ACC_W = 20,
  parameter int SHIFT = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DW-1:0]             act_in,
  input  logic                      act_valid,
  output logic                      act_ready,
  output logic [$clog2(N_IN)-1:0]   w_addr,
  input  logic [N_OUT*DW-1:0]       w_data,
  output logic [N_OUT*DW-1:0]       data_out,
  output logic                      data_valid,
  output logic                      busy
);

  localparam int AW = $clog2(N_IN);
  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

  mac_state_t            state;
  logic [AW-1:0]         cnt;
  logic [DW-1:0]         act_s1;
  logic                  v_s1;
  logic                  accept;
  logic                  clear_acc;
  logic [N_OUT*DW-1:0]   scores;

  assign accept    = act_valid & act_ready;
  assign clear_acc = (state == ST_IDLE) & start;
  assign w_addr    = cnt;

  // Stage 2: the ROM row for an accepted activation arrives one edge after the
  // accept, alongside act_s1, so each lane MACs when v_s1 is set.
  for (genvar d = 0; d < N_OUT; d++) begin : g_lane
    localparam int L = lane_of(d);
    sm_mac_lane #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_acc),
      .mac_en (v_s1),
      .act    (act_s1),
      .w      (w_data[L*DW +: DW]),
      .score  (scores[L*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      act_ready  <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      act_s1     <= '0;
      v_s1       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      v_s1       <= accept;
      if (accept) begin
        act_s1 <= act_in;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ACCUM;
            cnt       <= '0;
            act_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              act_ready <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        // Last product lands in the accumulators on the DRAIN edge.
        ST_DRAIN: begin
          state <= ST_QUANT;
        end
        ST_QUANT: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          data_out   <= scores;
          data_valid <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_mac.sv
// tb/tb_output_layer_mac.sv - directed self-checking bench for output_layer_mac
module tb_output_layer_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  act_in = 8'h00;
  logic        act_valid = 1'b0;
  logic        act_ready;
  logic [4:0]  w_addr;
  logic [79:0] w_data = '0;
  logic [79:0] data_out;
  logic        data_valid;
  logic        busy;

  logic [79:0] rom [0:31];
  int checks = 0;
  int errors = 0;
  logic [79:0] exp_stall;

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];

  output_layer_mac dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .act_in     (act_in),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  task automatic rom_clear();
    for (int a = 0; a < 32; a++) rom[a] = '0;
  endtask

  task automatic rom_set_lane(input int d, input logic [7:0] w);
    for (int a = 0; a < 32; a++) rom[a][(9-d)*8 +: 8] = w;
  endtask

  task automatic do_run(input logic [7:0] act, input bit stall, input int rst_at,
                        input int restart_at, output int lat, output logic [79:0] res,
                        output bit seen, output int addr_bad);
    int k;
    int acc_n;
    bit pend;
    lat = -1; res = '0; seen = 1'b0; addr_bad = 0; k = 0; acc_n = 0;
    @(negedge clk);
    start = 1'b1;
    act_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    while (k < 300) begin
      @(negedge clk);
      if (data_valid) begin
        seen = 1'b1; lat = k; res = data_out;
        break;
      end
      if (act_ready && w_addr !== 5'(acc_n)) addr_bad++;
      if (rst_at >= 0 && acc_n == rst_at) begin
        act_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      start = (restart_at >= 0 && acc_n == restart_at);
      act_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      act_in = act_valid ? act : 8'($urandom);
      pend = act_ready && act_valid;
      @(posedge clk);
      k++;
      if (pend) acc_n++;
    end
    start = 1'b0;
    act_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (act_ready !== 1'b0) begin errors++; $display("FAIL reset_act_ready got %0b want 0", act_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %0b want 0", data_valid); end
    checks++;
    if (data_out !== 80'h0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
    checks++;
    if (w_addr !== 5'd0) begin errors++; $display("FAIL reset_w_addr got %0d want 0", w_addr); end
    rst = 1'b0;
  endtask

  task automatic test_zero_act();
    int lat; logic [79:0] res; bit seen; int ab;
    for (int a = 0; a < 32; a++) rom[a] = {16'($urandom), 32'($urandom), 32'($urandom)};
    do_run(8'h00, 1'b0, -1, -1, lat, res, seen, ab);
    checks++;
    if (!seen || res !== 80'h0) begin errors++; $display("FAIL zero_act_data got %h seen %0b want 0", res, seen); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL zero_act_latency got %0d want 34", lat); end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_act_pulse valid %0b busy %0b want 0 0", data_valid, busy);
    end
  endtask

  task automatic test_single_neuron();
    int lat; logic [79:0] res; bit seen; int ab; logic [79:0] e;
    rom_clear();
    rom_set_lane(3, 8'h7F);
    e = '0; e[55:48] = 8'h1F;
    do_run(8'h01, 1'b0, -1, -1, lat, res, seen, ab);
    checks++;
    if (!seen || res !== e) begin errors++; $display("FAIL single_neuron got %h want %h", res, e); end
  endtask

  task automatic test_pos_sat();
    int lat; logic [79:0] res; bit seen; int ab; logic [79:0] e;
    rom_clear();
    rom_set_lane(0, 8'h7F);
    e = '0; e[79:72] = 8'h80;
    do_run(8'h7F, 1'b0, -1, -1, lat, res, seen, ab);
    checks++;
    if (!seen || res !== e) begin errors++; $display("FAIL pos_sat got %h want %h", res, e); end
  endtask

  task automatic test_neg_sat();
    int lat; logic [79:0] res; bit seen; int ab; logic [79:0] e;
    rom_clear();
    rom_set_lane(5, 8'hFF);
    rom_set_lane(2, 8'h81);
    rom_set_lane(7, 8'h80);
    e = '0; e[39:32] = 8'hFF; e[63:56] = 8'hA0;
    do_run(8'h7F, 1'b0, -1, -1, lat, res, seen, ab);
    checks++;
    if (!seen || res !== e) begin errors++; $display("FAIL neg_sat got %h want %h", res, e); end
    rom_clear();
    rom_set_lane(4, 8'h01);
    rom_set_lane(6, 8'h81);
    e = '0; e[47:40] = 8'h81;
    do_run(8'h81, 1'b0, -1, -1, lat, res, seen, ab);
    checks++;
    if (!seen || res !== e) begin errors++; $display("FAIL neg_floor got %h want %h", res, e); end
  endtask

  task automatic test_stall();
    int lat; logic [79:0] r0; logic [79:0] r1; bit s0; bit s1; int ab0; int ab1;
    rom_clear();
    for (int a = 0; a < 32; a++) begin
      rom[a][79:72] = 8'(a);
      rom[a][71:64] = 8'h7F;
      rom[a][7:0]   = (a < 16) ? 8'h7F : 8'h00;
    end
    exp_stall = '0; exp_stall[79:72] = 8'h03; exp_stall[71:64] = 8'h1F; exp_stall[7:0] = 8'h0F;
    do_run(8'h01, 1'b0, -1, -1, lat, r0, s0, ab0);
    checks++;
    if (!s0 || r0 !== exp_stall) begin errors++; $display("FAIL nostall_data got %h want %h", r0, exp_stall); end
    do_run(8'h01, 1'b1, -1, -1, lat, r1, s1, ab1);
    checks++;
    if (!s1 || r1 !== exp_stall) begin errors++; $display("FAIL stall_data got %h want %h", r1, exp_stall); end
    checks++;
    if (ab0 + ab1 != 0) begin errors++; $display("FAIL stall_w_addr got %0d bad addresses want 0", ab0 + ab1); end
  endtask

  task automatic test_abort();
    int lat; logic [79:0] res; bit seen; int ab;
    do_run(8'h01, 1'b0, 10, -1, lat, res, seen, ab);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    checks++;
    if (data_out !== 80'h0) begin errors++; $display("FAIL abort_data_out got %h want 0", data_out); end
    checks++;
    if (act_ready !== 1'b0 || w_addr !== 5'd0) begin
      errors++; $display("FAIL abort_handshake ready %0b addr %0d want 0 0", act_ready, w_addr);
    end
    rst = 1'b0;
    do_run(8'h01, 1'b0, -1, 5, lat, res, seen, ab);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL restart_ignored_latency got %0d want 34", lat); end
    checks++;
    if (!seen || res !== exp_stall) begin errors++; $display("FAIL restart_clean_data got %h want %h", res, exp_stall); end
  endtask

  initial begin
    rom_clear();
    test_reset();
    test_zero_act();
    test_single_neuron();
    test_pos_sat();
    test_neg_sat();
    test_stall();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
